// File: rtl/instr_sequencer_if.sv
// Host/processor-side bus of the instruction sequencer.
// master = host side that drives loads, control and proc_done.
// slave  = the sequencer itself.
interface instr_sequencer_if;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        abort;
    logic        proc_done;
    logic        proc_run;
    logic [15:0] proc_din;
    logic        busy;
    logic        finished;
    logic        error;
    logic [3:0]  pc;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, abort, proc_done,
        input  proc_run, proc_din, busy, finished, error, pc
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, abort, proc_done,
        output proc_run, proc_din, busy, finished, error, pc
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps a 16-entry program store into a processor,
// one instruction per proc_run / proc_done handshake, with a per-entry timeout.
// Latency: next proc_run one cycle after proc_done; all outputs registered.
module instr_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    instr_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Counter value in the WAIT cycle where the count reaches TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [4:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        proc_run_q, proc_run_d;
    logic [15:0] proc_din_q, proc_din_d;
    logic        busy_q, busy_d;
    logic        finished_q, finished_d;
    logic        error_q, error_d;

    // Program store has no reset so a program survives a reset pulse.
    logic [15:0] prog_q [16];

    logic store_we;
    logic last_entry;
    logic timeout_hit;

    assign store_we    = bus.load_en && (state_q == S_IDLE) && !reset;
    assign last_entry  = ({1'b0, pc_q} == (len_q - 5'd1));
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    // Program store write port, only open while idle.
    always_ff @(posedge clk_50MHz) begin
        if (store_we) begin
            prog_q[bus.load_addr] <= bus.load_data;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        error_d    = error_q;
        finished_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start beats abort here; abort has nothing to cancel
                if (bus.start) begin
                    len_d   = bus.prog_len;
                    pc_d    = 4'd0;
                    cnt_d   = 8'd0;
                    error_d = 1'b0;
                    if (bus.prog_len == 5'd0) begin
                        finished_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = 8'd0;
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // priority: abort, then proc_done, then timeout
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.proc_done) begin
                    if (last_entry) begin
                        finished_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // yet aligned with the state they describe.
        proc_run_d = (state_d == S_ISSUE);
        busy_d     = (state_d != S_IDLE);
        proc_din_d = 16'h0000;
        if (state_d != S_IDLE) begin
            // bypass a same-cycle store write so the first issue sees it
            if (store_we && (bus.load_addr == pc_d)) begin
                proc_din_d = bus.load_data;
            end else begin
                proc_din_d = prog_q[pc_d];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= 4'd0;
            len_q      <= 5'd0;
            cnt_q      <= 8'd0;
            proc_run_q <= 1'b0;
            proc_din_q <= 16'h0000;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            proc_run_q <= proc_run_d;
            proc_din_q <= proc_din_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            error_q    <= error_d;
        end
    end

    assign bus.proc_run = proc_run_q;
    assign bus.proc_din = proc_din_q;
    assign bus.busy     = busy_q;
    assign bus.finished = finished_q;
    assign bus.error    = error_q;
    assign bus.pc       = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, hand-written corner
// sequences, then randomized runs checked against a transaction-level model.
module tb_instr_sequencer;

    localparam int TO = 255;

    logic clk;
    logic reset;
    instr_sequencer_if bus ();

    instr_sequencer #(.TIMEOUT(TO)) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Expected program store contents (only entries written while idle).
    logic [15:0] mstore [16];
    logic        merr;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [3:0]  la;
        logic [15:0] ldat;
        logic [4:0]  plen;
        logic        st;
        logic        ab;
        logic        dn;
        logic        e_run;
        logic [15:0] e_din;
        logic        e_busy;
        logic        e_fin;
        logic        e_err;
        logic [3:0]  e_pc;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic rst, input logic ld, input logic [3:0] la,
                                input logic [15:0] ldat, input logic [4:0] plen,
                                input logic st, input logic ab, input logic dn,
                                input logic e_run, input logic [15:0] e_din,
                                input logic e_busy, input logic e_fin,
                                input logic e_err, input logic [3:0] e_pc);
        vec_t v;
        v.rst = rst; v.ld = ld; v.la = la; v.ldat = ldat; v.plen = plen;
        v.st = st; v.ab = ab; v.dn = dn;
        v.e_run = e_run; v.e_din = e_din; v.e_busy = e_busy;
        v.e_fin = e_fin; v.e_err = e_err; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle while the sequencer is busy, with random store writes that
    // must be ignored.
    task automatic bstep();
        bus.load_en   = 1'($urandom_range(0, 1));
        bus.load_addr = 4'($urandom_range(0, 15));
        bus.load_data = 16'($urandom);
        step();
        bus.load_en = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        step();
        bus.load_en = 1'b0;
        mstore[a] = d;
    endtask

    // Runs a program; proc_done arrives dly cycles after each proc_run.
    task automatic run_prog(input string tag, input int len, input int dly);
        bus.prog_len = 5'(len);
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < len; k++) begin
            chk({tag, ".run"}, 32'(bus.proc_run), 1);
            chk({tag, ".din"}, 32'(bus.proc_din), 32'(mstore[k]));
            chk({tag, ".pc"}, 32'(bus.pc), 32'(k));
            for (int j = 0; j < dly; j++) begin
                step();
                chk({tag, ".gap"}, 32'(bus.proc_run), 0);
            end
            bus.proc_done = 1'b1;
            step();
            bus.proc_done = 1'b0;
        end
        chk({tag, ".fin"}, 32'(bus.finished), 1);
        chk({tag, ".pc_end"}, 32'(bus.pc), 32'(len - 1));
        chk({tag, ".err"}, 32'(bus.error), 0);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
        step();
        chk({tag, ".fin_pulse"}, 32'(bus.finished), 0);
    endtask

    initial begin
        bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0; bus.prog_len = 0;
        bus.start = 0; bus.abort = 0; bus.proc_done = 0;
        reset = 1'b1;
        merr  = 1'b0;
        repeat (2) step();

        //          rst ld la  ldat      plen st ab dn  run din      busy fin err pc
        tbl[0]  = mk(1, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 16'h1001, 0,  0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 16'h1202, 0,  0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 2, 16'h4001, 0,  0, 1, 1,  0, 16'h0000, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0,  1, 0, 0,  0, 16'h0000, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 16'hABCD, 2,  1, 1, 0,  1, 16'hABCD, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 0,  0, 0, 1,  0, 16'hABCD, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 0,  0, 0, 1,  1, 16'h1202, 1, 0, 0, 1);
        tbl[9]  = mk(0, 1, 1, 16'hFFFF, 3,  1, 0, 0,  0, 16'h1202, 1, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 16'h1202, 1, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 16'h0000, 0,  0, 0, 1,  0, 16'h0000, 0, 1, 0, 1);
        tbl[12] = mk(0, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 16'h0000, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 16'h0000, 3,  1, 0, 0,  1, 16'hABCD, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 16'hABCD, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 16'h0000, 0,  0, 1, 1,  0, 16'h0000, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 16'h0000, 2,  1, 0, 0,  1, 16'hABCD, 1, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 16'hABCD, 1, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 16'h0000, 0,  0, 0, 1,  1, 16'h1202, 1, 0, 0, 1);
        tbl[19] = mk(1, 0, 0, 16'h0000, 0,  0, 0, 1,  0, 16'h0000, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 16'h0000, 1,  1, 0, 0,  1, 16'hABCD, 1, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 16'h0000, 0,  0, 0, 1,  0, 16'hABCD, 1, 0, 0, 0);
        tbl[22] = mk(1, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            reset         = tbl[i].rst;
            bus.load_en   = tbl[i].ld;
            bus.load_addr = tbl[i].la;
            bus.load_data = tbl[i].ldat;
            bus.prog_len  = tbl[i].plen;
            bus.start     = tbl[i].st;
            bus.abort     = tbl[i].ab;
            bus.proc_done = tbl[i].dn;
            step();
            chk($sformatf("tbl%0d.run", i),  32'(bus.proc_run), 32'(tbl[i].e_run));
            chk($sformatf("tbl%0d.din", i),  32'(bus.proc_din), 32'(tbl[i].e_din));
            chk($sformatf("tbl%0d.busy", i), 32'(bus.busy),     32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.fin", i),  32'(bus.finished), 32'(tbl[i].e_fin));
            chk($sformatf("tbl%0d.err", i),  32'(bus.error),    32'(tbl[i].e_err));
            chk($sformatf("tbl%0d.pc", i),   32'(bus.pc),       32'(tbl[i].e_pc));
        end
        reset = 0; bus.load_en = 0; bus.prog_len = 0; bus.start = 0;
        bus.abort = 0; bus.proc_done = 0;
        step();

        // Basic three-entry program, done three cycles after each issue.
        load(4'd0, 16'h1001);
        load(4'd1, 16'h1202);
        load(4'd2, 16'h4001);
        run_prog("prog3", 3, 3);

        // Timeout: proc_done never arrives.
        begin
            int  w;
            logic fin_seen;
            bus.prog_len = 5'd1; bus.start = 1'b1; step(); bus.start = 1'b0;
            chk("to.run", 32'(bus.proc_run), 1);
            w = 0;
            fin_seen = 1'b0;
            for (int i = 0; i < 400; i++) begin
                step();
                fin_seen = fin_seen | bus.finished;
                if (bus.busy) w++;
                else break;
            end
            chk("to.wait_cycles", 32'(w), 32'(TO));
            chk("to.err", 32'(bus.error), 1);
            chk("to.busy", 32'(bus.busy), 0);
            chk("to.no_fin", 32'(fin_seen), 0);
            bus.prog_len = 5'd0; bus.start = 1'b1; step(); bus.start = 1'b0;
            chk("to.err_clr", 32'(bus.error), 0);
            chk("to.len0_fin", 32'(bus.finished), 1);
            // proc_done in the very cycle the count reaches TIMEOUT
            bus.prog_len = 5'd1; bus.start = 1'b1; step(); bus.start = 1'b0;
            repeat (TO) step();
            chk("to_edge.busy", 32'(bus.busy), 1);
            bus.proc_done = 1'b1; step(); bus.proc_done = 1'b0;
            chk("to_edge.fin", 32'(bus.finished), 1);
            chk("to_edge.err", 32'(bus.error), 0);
        end

        // Sixteen entries, proc_done during ISSUE (ignored) and again in WAIT.
        for (int i = 0; i < 16; i++) load(4'(i), 16'($urandom));
        bus.prog_len = 5'd16; bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("p16.run", 32'(bus.proc_run), 1);
            chk("p16.din", 32'(bus.proc_din), 32'(mstore[k]));
            chk("p16.pc", 32'(bus.pc), 32'(k));
            bus.proc_done = 1'b1;
            step();
            step();
            bus.proc_done = 1'b0;
        end
        chk("p16.fin", 32'(bus.finished), 1);
        chk("p16.pc_end", 32'(bus.pc), 15);

        // Abort in WAIT of entry 2 together with proc_done and a store write.
        begin
            logic bad;
            bus.prog_len = 5'd4; bus.start = 1'b1; step(); bus.start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                step();
                bus.proc_done = 1'b1; step(); bus.proc_done = 1'b0;
            end
            chk("ab.pc", 32'(bus.pc), 2);
            step();
            bus.load_en = 1'b1; bus.load_addr = 4'd2; bus.load_data = ~mstore[2];
            bus.abort = 1'b1; bus.proc_done = 1'b1;
            step();
            bus.load_en = 1'b0; bus.abort = 1'b0; bus.proc_done = 1'b0;
            chk("ab.busy", 32'(bus.busy), 0);
            chk("ab.run", 32'(bus.proc_run), 0);
            chk("ab.fin", 32'(bus.finished), 0);
            bad = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                bad = bad | bus.proc_run | bus.finished;
            end
            chk("ab.quiet", 32'(bad), 0);
            run_prog("ab_rerun", 3, 2);
        end

        // Reset during WAIT of entry 1, then rerun the untouched program.
        bus.prog_len = 5'd3; bus.start = 1'b1; step(); bus.start = 1'b0;
        step();
        bus.proc_done = 1'b1; step(); bus.proc_done = 1'b0;
        step();
        chk("rst.pc_before", 32'(bus.pc), 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst.run",  32'(bus.proc_run), 0);
        chk("rst.din",  32'(bus.proc_din), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.fin",  32'(bus.finished), 0);
        chk("rst.err",  32'(bus.error), 0);
        chk("rst.pc",   32'(bus.pc), 0);
        run_prog("rst_rerun", 3, 1);

        // Randomized runs against the transaction-level model.
        merr = 1'b0;
        for (int r = 0; r < 30; r++) begin
            int  len;
            int  act;
            int  d;
            int  w;
            bit  ended;
            for (int n = 0; n < int'($urandom_range(0, 3)); n++)
                load(4'($urandom_range(0, 15)), 16'($urandom));
            chk("rnd.idle_busy", 32'(bus.busy), 0);
            chk("rnd.idle_err", 32'(bus.error), 32'(merr));
            len = $urandom_range(0, 16);
            bus.prog_len = 5'(len);
            bus.start    = 1'b1;
            bus.abort    = 1'(($urandom_range(0, 3) == 0));
            step();
            bus.start = 1'b0; bus.abort = 1'b0;
            merr = 1'b0;
            if (len == 0) begin
                chk("rnd.len0_fin", 32'(bus.finished), 1);
                chk("rnd.len0_busy", 32'(bus.busy), 0);
                chk("rnd.len0_run", 32'(bus.proc_run), 0);
            end
            ended = 1'b0;
            for (int k = 0; k < len && !ended; k++) begin
                chk("rnd.run", 32'(bus.proc_run), 1);
                chk("rnd.din", 32'(bus.proc_din), 32'(mstore[k]));
                chk("rnd.pc", 32'(bus.pc), 32'(k));
                chk("rnd.fin_early", 32'(bus.finished), 0);
                act = $urandom_range(0, 29);
                if (act == 0) begin
                    bstep();
                    w = bus.busy ? 1 : 0;
                    for (int i = 0; i < 400 && bus.busy; i++) begin
                        bstep();
                        if (bus.busy) w++;
                        else chk("rnd.to_fin", 32'(bus.finished), 0);
                    end
                    chk("rnd.to_cycles", 32'(w), 32'(TO));
                    chk("rnd.to_err", 32'(bus.error), 1);
                    merr  = 1'b1;
                    ended = 1'b1;
                end else if (act <= 2) begin
                    if (act == 2) bstep();
                    for (int i = 0; i < int'($urandom_range(0, 4)); i++) bstep();
                    bus.abort     = 1'b1;
                    bus.proc_done = 1'($urandom_range(0, 1));
                    bstep();
                    bus.abort = 1'b0; bus.proc_done = 1'b0;
                    chk("rnd.ab_busy", 32'(bus.busy), 0);
                    chk("rnd.ab_run", 32'(bus.proc_run), 0);
                    chk("rnd.ab_fin", 32'(bus.finished), 0);
                    chk("rnd.ab_err", 32'(bus.error), 0);
                    ended = 1'b1;
                end else begin
                    bus.proc_done = 1'($urandom_range(0, 1));
                    bstep();
                    bus.proc_done = 1'b0;
                    d = $urandom_range(0, 5);
                    for (int i = 0; i < d; i++) bstep();
                    bus.proc_done = 1'b1;
                    bstep();
                    bus.proc_done = 1'b0;
                    if (k == len - 1) begin
                        chk("rnd.fin", 32'(bus.finished), 1);
                        chk("rnd.pc_end", 32'(bus.pc), 32'(len - 1));
                        chk("rnd.err", 32'(bus.error), 0);
                        chk("rnd.busy_end", 32'(bus.busy), 0);
                    end
                end
            end
            step();
            chk("rnd.fin_pulse", 32'(bus.finished), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles to wait for proc_done per instruction (1..255).
REQ-002 clk_50MHz  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_en  input  1  write program entry when high and FSM in IDLE.
REQ-005 load_addr  input  4  program entry index 0..15.
REQ-006 load_data  input  16  instruction word written to load_addr.
REQ-007 prog_len  input  5  number of entries to execute, 0..16, sampled on start.
REQ-008 start  input  1  one-cycle request to begin execution at entry 0.
REQ-009 abort  input  1  terminate execution; FSM returns to IDLE.
REQ-010 proc_done  input  1  processor completion, single-cycle high.
REQ-011 proc_run  output  1  single-cycle issue strobe to processor.
REQ-012 proc_din  output  16  instruction word presented to processor.
REQ-013 busy  output  1  high in ISSUE or WAIT.
REQ-014 finished  output  1  one-cycle pulse when all entries complete.
REQ-015 error  output  1  sticky timeout flag, cleared by reset or next accepted start.
REQ-016 pc  output  4  index of entry currently issued or awaited.

Function
REQ-017 Program store: 16 x 16-bit registers, no reset; write only when load_en high and state IDLE; load_en ignored otherwise.
REQ-018 States: IDLE, ISSUE, WAIT; encoding free.
REQ-019 IDLE: start high -> latch len = prog_len, pc = 0, clear error; if len = 0 pulse finished next cycle and stay IDLE; else go ISSUE.
REQ-020 start while load_en same cycle in IDLE: both take effect; issued word 0 reflects the write if load_addr = 0.
REQ-021 ISSUE (one cycle): proc_run = 1, proc_din = prog[pc], timeout counter cleared to 0; next state WAIT.
REQ-022 proc_din holds prog[pc] in ISSUE and WAIT; 16'h0000 in IDLE.
REQ-023 WAIT: proc_done sampled only in WAIT; proc_done in ISSUE or IDLE ignored.
REQ-024 WAIT, proc_done high: if pc = len-1 -> pulse finished, go IDLE, pc held; else pc increments, go ISSUE.
REQ-025 Issue-to-issue minimum spacing: proc_done in cycle N -> next proc_run in cycle N+1.
REQ-026 WAIT: counter increments each cycle without proc_done; counter reaches TIMEOUT -> error = 1, go IDLE, no finished pulse.
REQ-027 proc_done in the same cycle the counter reaches TIMEOUT: proc_done wins, no error.
REQ-028 abort high in ISSUE or WAIT -> IDLE next cycle, no finished, error unchanged; abort wins over proc_done and timeout; abort in IDLE no effect.
REQ-029 start while busy ignored; start and abort same cycle in IDLE: start accepted.
REQ-030 Outputs registered; proc_run never high in two consecutive cycles.

Reset
REQ-031 reset high: state IDLE, pc = 0, len = 0, counter = 0, proc_run = 0, proc_din = 0, busy = 0, finished = 0, error = 0; program store contents retained.
REQ-032 reset asserted mid-execution aborts immediately; reset priority over all inputs.

Verification
REQ-033 Load 16'h1001, 16'h1202, 16'h4001; prog_len=3; start; model returns proc_done 3 cycles after each proc_run -> three proc_run pulses with those words in order, finished one cycle after third proc_done, pc=2, error=0.
REQ-034 prog_len=0, start -> finished pulses next cycle, proc_run never asserted, busy stays 0.
REQ-035 prog_len=1, proc_done withheld, TIMEOUT=255 -> error=1 after 255 WAIT cycles, state IDLE, no finished; next start clears error.
REQ-036 prog_len=16, proc_done same cycle as proc_run then one cycle later -> first done ignored, sequence still completes 16 entries, pc=15.
REQ-037 Abort during WAIT of entry 2 with proc_done same cycle -> IDLE, no further proc_run, no finished; load_en during busy leaves store unchanged.
REQ-038 reset pulse during WAIT of entry 1 -> all outputs at reset values next cycle; restart reruns the original program unchanged.
